// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, start/done handshake.
// Build option MULDIV_FAST_MUL_EN: single-cycle array multiply for MUL* ops (divide stays iterative).
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  kill_i,
  input  logic [2:0]            md_op_i,
  input  logic [DATA_WIDTH-1:0] md_op1_i,
  input  logic [DATA_WIDTH-1:0] md_op2_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] md_result_o
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  function automatic logic [W-1:0] neg_if(input logic c, input logic [W-1:0] v);
    return c ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] neg_if2(input logic c, input logic [2*W-1:0] v);
    return c ? -v : v;
  endfunction

  state_t           state_q;
  logic [2:0]       op_q;
  logic             neg_q;
  logic             neg_rem_q;
  logic             spec_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     rem_q;
  logic [2*W-1:0]   prod_q;
  logic             done_q;
  logic [W-1:0]     result_q;

  // Operand decode and special-case detection on the request inputs
  logic         in_div, in_s1, in_s2, op1_neg, op2_neg;
  logic         div_zero, div_ovf, special, fast_path;
  logic [W-1:0] op1_mag, op2_mag, spec_val;
  logic [2*W-1:0] mul_init_d;

  assign in_div   = md_op_i[2];
  assign in_s1    = (md_op_i == 3'b001) | (md_op_i == 3'b010) |
                    (md_op_i == 3'b100) | (md_op_i == 3'b110);
  assign in_s2    = (md_op_i == 3'b001) | (md_op_i == 3'b100) | (md_op_i == 3'b110);
  assign op1_neg  = in_s1 & md_op1_i[W-1];
  assign op2_neg  = in_s2 & md_op2_i[W-1];
  assign op1_mag  = neg_if(op1_neg, md_op1_i);
  assign op2_mag  = neg_if(op2_neg, md_op2_i);
  assign div_zero = in_div & (md_op2_i == '0);
  assign div_ovf  = in_div & ~md_op_i[0] & (md_op1_i == {1'b1, {(W-1){1'b0}}}) &
                    (md_op2_i == '1);
  assign special  = div_zero | div_ovf;
  assign spec_val = div_zero ? (md_op_i[1] ? md_op1_i : '1)
                             : (md_op_i[1] ? '0 : md_op1_i);

`ifdef MULDIV_FAST_MUL_EN
  assign fast_path  = ~in_div;
  assign mul_init_d = {{W{1'b0}}, op1_mag} * {{W{1'b0}}, op2_mag};
`else
  assign fast_path  = 1'b0;
  assign mul_init_d = {{W{1'b0}}, op2_mag};
`endif

  // One iteration of multiply (add-shift) and divide (restoring subtract)
  logic [W:0]   mul_sum_d, rem_sh_d, rem_diff_d;
  logic         q_bit_d;
  logic [W-1:0] rem_next_d;

  assign mul_sum_d  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign rem_sh_d   = {rem_q, a_q[W-1]};
  assign rem_diff_d = rem_sh_d - {1'b0, b_q};
  assign q_bit_d    = ~rem_diff_d[W];
  assign rem_next_d = q_bit_d ? rem_diff_d[W-1:0] : rem_sh_d[W-1:0];

  // Final sign fix-up and result selection
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, fin_res_d;

  assign prod_fix = neg_if2(neg_q, prod_q);
  assign quo_fix  = neg_if(neg_q, a_q);
  assign rem_fix  = neg_if(neg_rem_q, rem_q);

  always_comb begin
    fin_res_d = prod_fix[2*W-1:W];
    if (spec_q)                fin_res_d = a_q;
    else if (op_q[2])          fin_res_d = op_q[1] ? rem_fix : quo_fix;
    else if (op_q[1:0] == 2'b00) fin_res_d = prod_fix[W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      spec_q    <= 1'b0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      prod_q    <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && !kill_i) begin
            op_q      <= md_op_i;
            neg_q     <= op1_neg ^ op2_neg;
            neg_rem_q <= op1_neg;
            spec_q    <= special;
            b_q       <= op2_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            prod_q    <= mul_init_d;
            if (special) begin
              a_q     <= spec_val;
              state_q <= FIN;
            end else begin
              a_q     <= op1_mag;
              state_q <= fast_path ? FIN : CALC;
            end
          end
        end
        CALC: begin
          if (kill_i) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (op_q[2]) begin
              rem_q <= rem_next_d;
              a_q   <= {a_q[W-2:0], q_bit_d};
            end else begin
              prod_q <= {mul_sum_d, prod_q[W-1:1]};
            end
            if (cnt_q == CNT_LAST) state_q <= FIN;
          end
        end
        FIN: begin
          state_q <= IDLE;
          if (!kill_i) begin
            done_q   <= 1'b1;
            result_q <= fin_res_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign busy_o      = ~ready_o;
  assign done_o      = done_q;
  assign md_result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, kill/reset handling, random ops vs a reference model.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, kill;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          ready, busy, done;
  logic [W-1:0]  res;
  int            checks = 0;
  int            failures = 0;
  logic [W-1:0]  last_res;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .kill_i(kill),
    .md_op_i(op), .md_op1_i(a), .md_op2_i(b),
    .ready_o(ready), .busy_o(busy), .done_o(done), .md_result_o(res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32M semantics using 64-bit integer arithmetic
  function automatic logic [W-1:0] ref_md(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(x); sb = $signed(y);
    ua = longint'({32'b0, x}); ub = longint'({32'b0, y});
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (y == 0) return '1;
        if (x == 32'h8000_0000 && y == '1) return x;
        return $signed(x) / $signed(y);
      end
      3'd5: return (y == 0) ? '1 : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == '1) return '0;
        return $signed(x) % $signed(y);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    if (o[2]) begin
      if (y == 0 || (!o[0] && x == 32'h8000_0000 && y == '1)) return 1;
      return W + 1;
    end
    return FAST ? 1 : W + 1;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit poke, input string tag);
    logic [W-1:0] e;
    int el, got;
    e  = ref_md(o, x, y);
    el = exp_lat(o, x, y);
    got = -1;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    for (int i = 1; i <= 80; i++) begin
      start = (poke && el > 3 && i == 2);
      @(posedge clk); #1;
      if (done) begin got = i; break; end
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(got), 32'(el));
    chk({tag, " result"}, res, e);
    last_res = e;
    @(posedge clk); #1;
    chk({tag, " done pulse width"}, 32'(done), 32'd0);
    chk({tag, " ready after done"}, 32'({ready, busy}), 32'b10);
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit any_done;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0; last_res = '0;
    #12;
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", res, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'd7, 32'd6, 1'b0, "MUL 7x6");
    chk("MUL 7x6 const", res, 32'h0000_002A);
    run_op(3'd3, '1, '1, 1'b0, "MULHU ffff");
    chk("MULHU const", res, 32'hFFFF_FFFE);
    run_op(3'd1, '1, '1, 1'b0, "MULH -1x-1");
    chk("MULH const", res, 32'h0);
    run_op(3'd2, '1, 32'd2, 1'b0, "MULHSU -1x2");
    chk("MULHSU const", res, 32'hFFFF_FFFF);
    run_op(3'd4, -32'sd7, 32'd2, 1'b0, "DIV -7/2");
    chk("DIV const", res, 32'hFFFF_FFFD);
    run_op(3'd6, -32'sd7, 32'd2, 1'b0, "REM -7%2");
    chk("REM const", res, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 1'b1, "DIVU 100/7 poked");
    chk("DIVU const", res, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 1'b0, "REMU 100%7");
    chk("REMU const", res, 32'd2);
    run_op(3'd4, 32'd5, 32'd0, 1'b0, "DIV 5/0");
    chk("DIV0 const", res, 32'hFFFF_FFFF);
    run_op(3'd7, 32'd5, 32'd0, 1'b0, "REMU 5%0");
    chk("REMU0 const", res, 32'd5);
    run_op(3'd4, 32'h8000_0000, '1, 1'b0, "DIV ovf");
    chk("DIV ovf const", res, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, '1, 1'b0, "REM ovf");
    chk("REM ovf const", res, 32'h0);

    // Kill mid-CALC
    op = 3'd5; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    chk("kill calc ready", 32'(ready), 32'd1);
    chk("kill calc done", 32'(done), 32'd0);
    chk("kill calc result held", res, last_res);
    any_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) any_done = 1'b1; end
    chk("kill calc no late done", 32'(any_done), 32'd0);

    // Kill together with start in IDLE
    op = 3'd5; a = 32'd50; b = 32'd5; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1; start = 1'b0; kill = 1'b0;
    chk("kill+start ready", 32'(ready), 32'd1);
    any_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done) any_done = 1'b1; end
    chk("kill+start no done", 32'(any_done), 32'd0);

    // Kill in FIN of a special-case op
    op = 3'd4; a = 32'd5; b = 32'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    chk("kill fin special done", 32'(done), 32'd0);
    chk("kill fin special result", res, last_res);

    // Kill in FIN of an iterative divide
    op = 3'd5; a = 32'd77; b = 32'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (W) @(posedge clk);
    #1; kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    chk("kill fin calc done", 32'(done), 32'd0);
    chk("kill fin calc result", res, last_res);
    chk("kill fin calc ready", 32'(ready), 32'd1);

    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] x, y;
      x = pick_val(); y = pick_val();
      run_op(3'($urandom), x, y, (k % 4 == 0), $sformatf("rand%0d", k));
    end

    // Asynchronous reset mid-operation
    op = 3'd3; a = $urandom; b = $urandom; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk("async rst ready", 32'(ready), 32'd1);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst done", 32'(done), 32'd0);
    chk("async rst result", res, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'd4, -32'sd100, 32'd7, 1'b0, "post-reset DIV");
    run_op(3'd2, 32'h8000_0000, '1, 1'b0, "post-reset MULHSU");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
